// File: rtl/cu_sequencer_pkg.sv
// rtl/cu_sequencer_pkg.sv - shared state, opcode and ACC-source encodings for the control unit
package cu_sequencer_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_IDLE,
        S_F0,
        S_F1,
        S_DEC,
        S_E0,
        S_E1,
        S_E2,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ACC_SEL_MEM = 2'd0;
    localparam logic [1:0] ACC_SEL_ALU = 2'd1;
    localparam logic [1:0] ACC_SEL_IMM = 2'd2;

endpackage

// File: rtl/cu_opdecode.sv
// rtl/cu_opdecode.sv - opcode to execute-phase length flags
module cu_opdecode
    import cu_sequencer_pkg::*;
(
    input  logic [3:0] op,
    output logic       needs_e0,
    output logic       needs_e1,
    output logic       needs_e2
);

    always_comb begin
        needs_e0 = 1'b0;
        needs_e1 = 1'b0;
        needs_e2 = 1'b0;
        case (op)
            OP_LDA, OP_STA: begin
                needs_e0 = 1'b1;
                needs_e1 = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                needs_e0 = 1'b1;
                needs_e1 = 1'b1;
                needs_e2 = 1'b1;
            end
            OP_LDI, OP_JMP, OP_JZ, OP_JC, OP_OUT: needs_e0 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - fetch/decode/execute strobe sequencer for the 8-bit accumulator CPU
module cu_sequencer
    import cu_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             run,
    input  logic             step_mode,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             carry_flag,
    output logic             ir_load,
    output logic             ir_clear,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_clear,
    output logic             mar_sel,
    output logic             mar_load,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             b_load,
    output logic             acc_load,
    output logic [1:0]       acc_sel,
    output logic             alu_sub,
    output logic             out_load,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               go, needs_e0, needs_e1, needs_e2;
    logic [3:0]         dec_op;
    state_e             end_state;

    // In S_DEC the fresh opcode decides the path; op_q is only valid afterwards.
    assign dec_op = (state_q == S_DEC) ? opcode : op_q;

    cu_opdecode u_opdecode (
        .op       (dec_op),
        .needs_e0 (needs_e0),
        .needs_e1 (needs_e1),
        .needs_e2 (needs_e2)
    );

    assign go        = run & ~run_q;
    assign end_state = (step_mode || !run) ? S_IDLE : S_F0;
    assign instr_cnt = cnt_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        run_d    = run;
        ir_load  = 1'b0;
        ir_clear = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        pc_clear = 1'b0;
        mar_sel  = 1'b0;
        mar_load = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        b_load   = 1'b0;
        acc_load = 1'b0;
        acc_sel  = ACC_SEL_MEM;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        halted   = 1'b0;
        busy     = 1'b1;
        case (state_q)
            S_RST: begin
                ir_clear = 1'b1;
                pc_clear = 1'b1;
                busy     = 1'b0;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                busy = 1'b0;
                if (go) state_d = S_F0;
            end
            S_F0: begin
                mar_load = 1'b1;
                state_d  = S_F1;
            end
            S_F1: begin
                mem_rd  = 1'b1;
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                op_d  = opcode;
                cnt_d = cnt_q + CNT_W'(1);
                if (opcode == OP_HLT) state_d = S_HALT;
                else if (needs_e0)    state_d = S_E0;
                else                  state_d = end_state;
            end
            S_E0: begin
                case (op_q)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        mar_sel  = 1'b1;
                        mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        acc_load = 1'b1;
                        acc_sel  = ACC_SEL_IMM;
                    end
                    OP_JMP:  pc_load  = 1'b1;
                    OP_JZ:   pc_load  = zero_flag;
                    OP_JC:   pc_load  = carry_flag;
                    OP_OUT:  out_load = 1'b1;
                    default: ;
                endcase
                state_d = needs_e1 ? S_E1 : end_state;
            end
            S_E1: begin
                case (op_q)
                    OP_LDA: begin
                        mem_rd   = 1'b1;
                        acc_load = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        mem_rd = 1'b1;
                        b_load = 1'b1;
                    end
                    OP_STA:  mem_wr = 1'b1;
                    default: ;
                endcase
                state_d = needs_e2 ? S_E2 : end_state;
            end
            S_E2: begin
                acc_load = 1'b1;
                acc_sel  = ACC_SEL_ALU;
                alu_sub  = (op_q == OP_SUB);
                state_d  = end_state;
            end
            S_HALT: begin
                halted = 1'b1;
                busy   = 1'b0;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_RST;
            op_q    <= 4'h0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - directed table-driven bench for cu_sequencer with a small datapath model
module tb_cu_sequencer;

    logic       clk = 1'b0;
    logic       clear = 1'b0, run = 1'b0, step_mode = 1'b0;
    logic [3:0] opcode;
    logic       zf = 1'b0, cf = 1'b0;
    logic       ir_load, ir_clear, pc_inc, pc_load, pc_clear, mar_sel, mar_load;
    logic       mem_rd, mem_wr, b_load, acc_load, alu_sub, out_load, halted, busy;
    logic [1:0] acc_sel;
    logic [7:0] instr_cnt;

    always #5 clk = ~clk;

    cu_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .clear(clear), .run(run), .step_mode(step_mode), .opcode(opcode),
        .zero_flag(zf), .carry_flag(cf), .ir_load(ir_load), .ir_clear(ir_clear),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_clear(pc_clear), .mar_sel(mar_sel),
        .mar_load(mar_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .b_load(b_load),
        .acc_load(acc_load), .acc_sel(acc_sel), .alu_sub(alu_sub), .out_load(out_load),
        .halted(halted), .busy(busy), .instr_cnt(instr_cnt)
    );

    // Datapath model: strobes snapshotted mid-cycle, applied on the next rising edge.
    logic [7:0] mem [16];
    logic [7:0] ir_m = 8'h00, acc_m = 8'h00, b_m = 8'h00, out_m = 8'h00;
    logic [3:0] pc_m = 4'h0, mar_m = 4'h0;
    int         out_cnt = 0, viol = 0;
    logic       s_irl, s_irc, s_pci, s_pcl, s_pcc, s_msel, s_mld, s_wr, s_bl, s_al, s_sub, s_ol;
    logic [1:0] s_asel;

    assign opcode = ir_m[7:4];

    always @(negedge clk) begin
        s_irl = ir_load;  s_irc = ir_clear; s_pci = pc_inc;   s_pcl = pc_load;
        s_pcc = pc_clear; s_msel = mar_sel; s_mld = mar_load; s_wr = mem_wr;
        s_bl = b_load;    s_al = acc_load;  s_sub = alu_sub;  s_ol = out_load;
        s_asel = acc_sel;
        if ((mem_rd && mem_wr) || (32'(pc_inc) + 32'(pc_load) + 32'(pc_clear) > 1)) viol++;
    end

    always @(posedge clk) begin
        logic [7:0] rd;
        rd = mem[mar_m];
        if (s_wr) mem[mar_m] = acc_m;
        if (s_bl) b_m = rd;
        if (s_ol) begin out_m = acc_m; out_cnt++; end
        if (s_al) begin
            case (s_asel)
                2'd0:    acc_m = rd;
                2'd1:    acc_m = s_sub ? acc_m - b_m : acc_m + b_m;
                default: acc_m = {4'h0, ir_m[3:0]};
            endcase
        end
        if (s_pcc) pc_m = 4'h0;
        else if (s_pcl) pc_m = ir_m[3:0];
        else if (s_pci) pc_m = pc_m + 4'h1;
        if (s_mld) mar_m = s_msel ? ir_m[3:0] : pc_m;
        if (s_irc) ir_m = 8'h00;
        else if (s_irl) ir_m = rd;
    end

    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] cur_mask();
        return {ir_load, pc_inc, pc_load, mar_load, mem_rd, mem_wr, b_load, acc_load, out_load, alu_sub};
    endfunction

    task automatic do_clear();
        @(negedge clk); clear = 1'b1; run = 1'b0;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic run_one(output int cyc, output logic [9:0] m);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        cyc = 0; m = '0;
        while (busy && cyc < 20) begin
            m |= cur_mask();
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic       zf;
        logic       cf;
        int         cyc;
        logic [9:0] mask;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int         cyc, n;
        logic [9:0] m;
        logic [7:0] cnt0, dcnt;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        // mask bits: ir_load pc_inc pc_load mar_load mem_rd mem_wr b_load acc_load out_load alu_sub
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 3, 10'b11_0_1_1_0_0_0_0_0};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 5, 10'b11_0_1_1_0_0_1_0_0};
        vecs[2]  = '{4'h2, 1'b0, 1'b0, 6, 10'b11_0_1_1_0_1_1_0_0};
        vecs[3]  = '{4'h3, 1'b0, 1'b0, 6, 10'b11_0_1_1_0_1_1_0_1};
        vecs[4]  = '{4'h4, 1'b0, 1'b0, 5, 10'b11_0_1_1_1_0_0_0_0};
        vecs[5]  = '{4'h5, 1'b0, 1'b0, 4, 10'b11_0_1_1_0_0_1_0_0};
        vecs[6]  = '{4'h6, 1'b0, 1'b0, 4, 10'b11_1_1_1_0_0_0_0_0};
        vecs[7]  = '{4'h7, 1'b1, 1'b0, 4, 10'b11_1_1_1_0_0_0_0_0};
        vecs[8]  = '{4'h7, 1'b0, 1'b1, 4, 10'b11_0_1_1_0_0_0_0_0};
        vecs[9]  = '{4'h8, 1'b0, 1'b1, 4, 10'b11_1_1_1_0_0_0_0_0};
        vecs[10] = '{4'h8, 1'b1, 1'b0, 4, 10'b11_0_1_1_0_0_0_0_0};
        vecs[11] = '{4'hE, 1'b0, 1'b0, 4, 10'b11_0_1_1_0_0_0_1_0};
        vecs[12] = '{4'hB, 1'b0, 1'b0, 3, 10'b11_0_1_1_0_0_0_0_0};

        // reset state
        @(negedge clk); clear = 1'b1;
        @(negedge clk);
        chk("rst_ir_clear", int'(ir_clear), 1);
        chk("rst_pc_clear", int'(pc_clear), 1);
        chk("rst_other_strobes", int'(cur_mask()), 0);
        clear = 1'b0;
        @(negedge clk);
        chk("idle_strobes", int'({cur_mask(), ir_clear, pc_clear, halted, busy}), 0);
        chk("idle_cnt", int'(instr_cnt), 0);

        // single-step through every opcode class
        step_mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            mem[pc_m] = {vecs[i].op, 4'hC};
            zf = vecs[i].zf;
            cf = vecs[i].cf;
            cnt0 = instr_cnt;
            run_one(cyc, m);
            dcnt = instr_cnt - cnt0;
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("v%0d_mask", i), int'(m), int'(vecs[i].mask));
            chk($sformatf("v%0d_cnt_delta", i), int'(dcnt), 1);
        end

        // held run advances exactly one instruction in step mode
        mem[pc_m] = 8'h00;
        cnt0 = instr_cnt;
        @(negedge clk); run = 1'b1;
        repeat (20) @(negedge clk);
        dcnt = instr_cnt - cnt0;
        chk("held_run_one_instr", int'(dcnt), 1);
        chk("held_run_idle", int'(busy), 0);
        run = 1'b0;

        // HLT parks until clear, ignoring run edges
        mem[pc_m] = 8'hF0;
        run_one(cyc, m);
        chk("hlt_cycles", cyc, 3);
        chk("hlt_halted", int'(halted), 1);
        cnt0 = instr_cnt;
        repeat (3) begin
            @(negedge clk); run = 1'b1;
            @(negedge clk); run = 1'b0;
        end
        chk("hlt_stays", int'({halted, busy}), 2);
        chk("hlt_cnt_frozen", int'(instr_cnt), int'(cnt0));

        // clear during S_E1 of STA
        do_clear();
        mem[0] = 8'h4C;
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        repeat (4) @(negedge clk);
        chk("sta_e1_mem_wr", int'(mem_wr), 1);
        clear = 1'b1;
        @(negedge clk);
        chk("sta_clr_no_wr", int'(mem_wr), 0);
        chk("sta_clr_rst", int'({ir_clear, pc_clear}), 3);
        chk("sta_clr_cnt", int'(instr_cnt), 0);
        clear = 1'b0;

        // free-running program: LDI 3; ADD 4; OUT; HLT with mem[4]=5
        mem[0] = 8'h53; mem[1] = 8'h24; mem[2] = 8'hE0; mem[3] = 8'hF0; mem[4] = 8'h05;
        step_mode = 1'b0;
        do_clear();
        out_cnt = 0;
        @(negedge clk); run = 1'b1;
        n = 0;
        while (!halted && n < 200) begin @(negedge clk); n++; end
        chk("prog_halted", int'(halted), 1);
        chk("prog_acc", int'(acc_m), 8);
        chk("prog_out", int'(out_m), 8);
        chk("prog_out_loads", out_cnt, 1);
        chk("prog_cnt", int'(instr_cnt), 4);
        run = 1'b0;

        // 256 NOPs wrap the counter; NOP spacing is 3 cycles
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        do_clear();
        @(negedge clk); run = 1'b1;
        n = 0;
        while (instr_cnt != 8'd255 && n < 2000) begin @(negedge clk); n++; end
        chk("wrap_reached_255", int'(instr_cnt), 255);
        cyc = 0;
        while (instr_cnt == 8'd255 && cyc < 10) begin @(negedge clk); cyc++; end
        chk("wrap_to_zero", int'(instr_cnt), 0);
        chk("wrap_nop_spacing", cyc, 3);
        run = 1'b0;
        repeat (5) @(negedge clk);
        chk("free_run_stops", int'(busy), 0);

        chk("strobe_exclusion", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
